// File: rtl/sub_sat_accum.sv
// Saturating accumulator for bursts of subtractor results: clamps overflowed differences,
// sums them with signed saturation, counts overflow beats and hands the total downstream.
module sub_sat_accum #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_diff,
   input  logic             in_ovf,
   input  logic             in_a_msb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_sat,
   output logic [CNT_W-1:0] out_ovf_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           r_state;
   logic [LEN_W-1:0] r_remaining;
   logic [WIDTH-1:0] r_sum;
   logic             r_sat;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_in_ready;
   logic             r_out_valid;

   logic             w_accept;
   logic [WIDTH-1:0] w_clamped;
   logic [WIDTH:0]   w_sum_ext;
   logic             w_sum_ovf;
   logic [WIDTH-1:0] w_sum_sat;

   // On a-b overflow the true result carries the sign of a, so clamp toward that limit.
   assign w_accept  = in_valid & r_in_ready;
   assign w_clamped = in_ovf ? (in_a_msb ? SMIN : SMAX) : in_diff;
   assign w_sum_ext = {r_sum[WIDTH-1], r_sum} + {w_clamped[WIDTH-1], w_clamped};
   assign w_sum_ovf = w_sum_ext[WIDTH] ^ w_sum_ext[WIDTH-1];
   assign w_sum_sat = w_sum_ovf ? (w_sum_ext[WIDTH] ? SMIN : SMAX) : w_sum_ext[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_sum       <= '0;
         r_sat       <= 1'b0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_remaining <= len;
                  r_sum       <= '0;
                  r_sat       <= 1'b0;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
                  if (len != '0) begin
                     r_state    <= S_ACC;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_ACC: begin
               if (w_accept) begin
                  r_sum       <= w_sum_sat;
                  r_sat       <= r_sat | w_sum_ovf;
                  r_remaining <= r_remaining - 1'b1;
                  if (in_ovf && (r_cnt != CNT_MAX)) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
                  if (r_remaining == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                     r_state     <= S_DONE;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_sum     = r_sum;
   assign out_sat     = r_sat;
   assign out_ovf_cnt = r_cnt;

endmodule

// File: tb/tb_sub_sat_accum.sv
// Randomized and directed bursts for sub_sat_accum; expected totals come from an
// integer reference model and are checked by an independent output monitor.
module tb_sub_sat_accum;

   localparam int WIDTH = 32;
   localparam int CNT_W = 8;
   localparam int LEN_W = 9;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct {
      logic [31:0] sum;
      logic        sat;
      logic [7:0]  cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic             busy;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_diff = '0;
   logic             in_ovf = 1'b0;
   logic             in_a_msb = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_sum;
   logic             out_sat;
   logic [CNT_W-1:0] out_ovf_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int n_txn    = 0;

   exp_t        exp_q[$];
   exp_t        last_exp;
   logic [31:0] b_diff[$];
   bit          b_ovf[$];
   bit          b_msb[$];

   sub_sat_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_diff(in_diff),
      .in_ovf(in_ovf), .in_a_msb(in_a_msb), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat),
      .out_ovf_cnt(out_ovf_cnt)
   );

   always #5 clk = ~clk;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
   endfunction

   // Reference: plain integer arithmetic with explicit clamping to the 32-bit signed range.
   function automatic exp_t model();
      exp_t   e;
      longint s = 0;
      longint v;
      bit     sat = 0;
      int     c = 0;
      for (int i = 0; i < b_diff.size(); i++) begin
         if (b_ovf[i]) v = b_msb[i] ? SMIN : SMAX;
         else          v = longint'($signed(b_diff[i]));
         s = s + v;
         if (s > SMAX) begin s = SMAX; sat = 1; end
         else if (s < SMIN) begin s = SMIN; sat = 1; end
         if (b_ovf[i] && c < 255) c++;
      end
      e.sum = s[31:0];
      e.sat = sat;
      e.cnt = c[7:0];
      return e;
   endfunction

   // Output monitor: every presented result must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: got sum 0x%08h, expected no result", out_sum);
         end else begin
            check("out_sum", out_sum, exp_q[0].sum);
            check("out_sat", {31'd0, out_sat}, {31'd0, exp_q[0].sat});
            check("out_ovf_cnt", {24'd0, out_ovf_cnt}, {24'd0, exp_q[0].cnt});
            if (out_ready) begin
               last_exp = exp_q.pop_front();
               n_txn++;
               $display("txn %0d: sum=0x%08h sat=%0d ovf_cnt=%0d", n_txn, out_sum, out_sat, out_ovf_cnt);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_beats();
      b_diff.delete();
      b_ovf.delete();
      b_msb.delete();
   endtask

   task automatic push_beat(logic [31:0] d, bit o, bit m);
      b_diff.push_back(d);
      b_ovf.push_back(o);
      b_msb.push_back(m);
   endtask

   task automatic start_burst(int l);
      start = 1'b1;
      len   = l[LEN_W-1:0];
      tick();
      start = 1'b0;
      len   = LEN_W'($urandom);
      check("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic send_beat(int i, int gap, bit last);
      int k;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         in_diff   = $urandom;
         in_ovf    = 1'($urandom);
         out_ready = 1'($urandom);
         tick();
      end
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_diff   = b_diff[i];
      in_ovf    = b_ovf[i];
      in_a_msb  = b_msb[i];
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         n_checks++;
         $display("FAIL beat_accept_timeout: got in_ready=0, expected 1 within 100 cycles");
      end
      tick();
      in_valid = 1'b0;
      in_diff  = $urandom;
      in_ovf   = 1'($urandom);
      in_a_msb = 1'($urandom);
      if (last) begin
         @(negedge clk);
         check("out_valid_latency", {31'd0, out_valid}, 32'd1);
      end
   endtask

   task automatic finish_burst(int stall);
      int k = 0;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!out_valid) begin
         n_checks++;
         $display("FAIL out_valid_timeout: got out_valid=0, expected 1 within 100 cycles");
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < stall; s++) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("busy_after_handshake", {31'd0, busy}, 32'd0);
      check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
      check("out_sum_retained", out_sum, last_exp.sum);
   endtask

   task automatic run_burst(int maxgap, int stall, bit poke_start);
      int l = b_diff.size();
      exp_q.push_back(model());
      start_burst(l);
      if (l == 0) check("len0_done", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < l; i++) begin
         if (poke_start && i == 1) begin
            start = 1'b1;
            len   = 1;
            tick();
            start = 1'b0;
         end
         send_beat(i, $urandom_range(0, maxgap), i == l - 1);
      end
      finish_burst(stall);
   endtask

   initial begin
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out_sum", out_sum, 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Basic burst
      clear_beats();
      push_beat(32'd5, 0, 0); push_beat(32'hFFFF_FFFE, 0, 0); push_beat(32'd10, 0, 0);
      run_burst(0, 0, 0);

      // Overflow clamping toward the sign of a
      clear_beats();
      push_beat($urandom, 1, 0); push_beat($urandom, 1, 1);
      run_burst(1, 0, 0);

      // Positive then negative accumulator saturation
      clear_beats();
      push_beat(32'h7FFF_FFF0, 0, 0); push_beat(32'h20, 0, 0); push_beat(32'hFFFF_FFFB, 0, 0);
      run_burst(1, 0, 0);
      clear_beats();
      push_beat(32'h8000_0010, 0, 0); push_beat(32'hFFFF_FFE0, 0, 0);
      run_burst(1, 0, 0);

      // Input gaps and output back-pressure
      clear_beats();
      for (int i = 0; i < 4; i++) push_beat($urandom_range(0, 1000), 0, 0);
      run_burst(3, 5, 0);

      // Zero-length burst
      clear_beats();
      run_burst(0, 2, 0);

      // Start pulse during accumulation must not reload the length
      clear_beats();
      for (int i = 0; i < 4; i++) push_beat($urandom_range(0, 50), 0, 0);
      run_burst(1, 0, 1);

      // Overflow counter saturation
      clear_beats();
      for (int i = 0; i < 300; i++) push_beat($urandom, 1, 1'($urandom));
      run_burst(0, 0, 0);

      // Reset in the middle of a burst
      clear_beats();
      for (int i = 0; i < 4; i++) push_beat($urandom_range(1, 100), 1, 0);
      start_burst(4);
      send_beat(0, 0, 0);
      send_beat(1, 1, 0);
      #2;
      rst = 1'b1;
      #1;
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_in_ready", {31'd0, in_ready}, 32'd0);
      check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      check("midreset_out_sum", out_sum, 32'd0);
      check("midreset_out_sat", {31'd0, out_sat}, 32'd0);
      check("midreset_out_ovf_cnt", {24'd0, out_ovf_cnt}, 32'd0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      clear_beats();
      push_beat(32'd7, 0, 0);
      run_burst(0, 0, 0);

      // Random bursts
      for (int b = 0; b < 25; b++) begin
         int l = $urandom_range(1, 8);
         clear_beats();
         for (int i = 0; i < l; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
            push_beat(d, $urandom_range(0, 4) == 0, 1'($urandom));
         end
         run_burst(3, $urandom_range(0, 3), 0);
      end

      repeat (3) tick();
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL leftover_results: got %0d pending, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
